// File: rtl/hex_keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
// Holds the FSM state encoding, column/row constants and the active-low row decoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  localparam logic [3:0] COL_INIT = 4'b1110;
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // Index of the low bit in an active-low one-hot nibble.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // {hit, idx}: hit only when exactly one row is pulled low; multi-key is idle.
  function automatic logic [2:0] row_decode(input logic [3:0] row);
    logic hit;
    hit = ($countones(~row) == 1);
    return {hit, low_idx(row)};
  endfunction

endpackage

// File: rtl/hex_keypad_scan_if.sv
// Keypad-side signal bundle: row sense in, column drive and decoded key out.
interface hex_keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (output row, input col, key_code, key_valid, key_down);
  modport slave  (input row, output col, key_code, key_valid, key_down);
endinterface

// File: rtl/hex_keypad_scan_sync_2ff.sv
// Generic two-flop synchronizer with async active-low reset to a chosen value.
module sync_2ff #(
  parameter int unsigned     WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hex_keypad_scan.sv
// 4x4 hex keypad scanner: rotates an active-low column, debounces presses and
// releases over DEBOUNCE_TICKS scan ticks, and reports key_code/key_valid/key_down.
module hex_keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 16,
  parameter int unsigned DEBOUNCE_TICKS = 8
) (
  input  logic             clk,
  input  logic             reset,
  hex_keypad_scan_if.slave kp
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_TICKS);

  logic [DIV_W-1:0] r_div;
  state_e           r_state, w_state;
  logic [3:0]       r_col, w_col;
  logic [3:0]       r_code, w_code;
  logic             r_valid, w_valid;
  logic             r_down, w_down;
  logic [DEB_W-1:0] r_deb, w_deb;
  logic [1:0]       r_cand_row, w_cand_row;
  logic [1:0]       r_cand_col, w_cand_col;

  logic [3:0]       w_row_s;
  logic [2:0]       w_dec;
  logic             w_tick;
  logic             w_hit;
  logic [1:0]       w_idx;
  logic [1:0]       w_col_idx;
  logic [3:0]       w_rot;
  logic [DEB_W-1:0] w_deb_inc;
  logic             w_accept;
  logic [3:0]       w_acc_code;

  sync_2ff #(.WIDTH(4), .RST_VAL(ROW_IDLE)) u_row_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (kp.row),
    .o_q     (w_row_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  assign w_tick    = (r_div == DIV_LAST);
  assign w_dec     = row_decode(w_row_s);
  assign w_hit     = w_dec[2];
  assign w_idx     = w_dec[1:0];
  assign w_col_idx = low_idx(r_col);
  assign w_rot     = {r_col[2:0], r_col[3]};
  assign w_deb_inc = (r_deb == DEB_MAX) ? r_deb : r_deb + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= SCAN;
      r_col      <= COL_INIT;
      r_code     <= '0;
      r_valid    <= 1'b0;
      r_down     <= 1'b0;
      r_deb      <= '0;
      r_cand_row <= '0;
      r_cand_col <= '0;
    end else begin
      r_state    <= w_state;
      r_col      <= w_col;
      r_code     <= w_code;
      r_valid    <= w_valid;
      r_down     <= w_down;
      r_deb      <= w_deb;
      r_cand_row <= w_cand_row;
      r_cand_col <= w_cand_col;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_col      = r_col;
    w_code     = r_code;
    w_valid    = 1'b0;
    w_down     = r_down;
    w_deb      = r_deb;
    w_cand_row = r_cand_row;
    w_cand_col = r_cand_col;
    w_accept   = 1'b0;
    w_acc_code = {r_cand_row, r_cand_col};

    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_hit) begin
            w_cand_row = w_idx;
            w_cand_col = w_col_idx;
            w_state    = DEBOUNCE;
            w_deb      = DEB_W'(1);
            // A single-tick debounce accepts on the very first hit.
            if (DEB_MAX == DEB_W'(1)) begin
              w_accept   = 1'b1;
              w_acc_code = {w_idx, w_col_idx};
            end
          end else begin
            w_col = w_rot;
          end
        end
        DEBOUNCE: begin
          if (w_hit && (w_idx == r_cand_row)) begin
            w_deb = w_deb_inc;
            if (w_deb_inc == DEB_MAX) w_accept = 1'b1;
          end else begin
            w_state = SCAN;
            w_col   = w_rot;
            w_deb   = '0;
          end
        end
        HELD: begin
          if (w_hit) begin
            w_deb = '0;
          end else if (w_deb_inc == DEB_MAX) begin
            w_down  = 1'b0;
            w_state = SCAN;
            w_col   = w_rot;
            w_deb   = '0;
          end else begin
            w_deb = w_deb_inc;
          end
        end
        default: begin
          w_state = SCAN;
          w_col   = COL_INIT;
          w_deb   = '0;
        end
      endcase
    end

    if (w_accept) begin
      w_code  = w_acc_code;
      w_valid = 1'b1;
      w_down  = 1'b1;
      w_deb   = '0;
      w_state = HELD;
    end
  end

  assign kp.col       = r_col;
  assign kp.key_code  = r_code;
  assign kp.key_valid = r_valid;
  assign kp.key_down  = r_down;

endmodule
